// File: rtl/bcd_7seg_scan_if.sv
// Datapath-to-display bus for bcd_7seg_scan: BCD word, decimal points and
// display controls in, multiplexed segment/anode pins and error flag out.
interface bcd_7seg_scan_if #(
  parameter int NUM_DIGITS = 4
);
  logic [4*NUM_DIGITS-1:0] bcd_in;
  logic [NUM_DIGITS-1:0]   dp_in;
  logic                    load;
  logic                    blank_lz;
  logic [NUM_DIGITS-1:0]   blink_mask;
  logic [6:0]              seg_out;
  logic                    dp_out;
  logic [NUM_DIGITS-1:0]   digit_en;
  logic                    err;

  modport master (
    output bcd_in, dp_in, load, blank_lz, blink_mask,
    input  seg_out, dp_out, digit_en, err
  );

  modport slave (
    input  bcd_in, dp_in, load, blank_lz, blink_mask,
    output seg_out, dp_out, digit_en, err
  );
endinterface

// File: rtl/bcd_7seg_scan.sv
// Time-multiplexed BCD to 7-segment driver for an N-digit common-anode display
// with leading-zero blanking, per-digit blink, decimal points and error flag.
module bcd_7seg_scan #(
  parameter int NUM_DIGITS   = 4,
  parameter int SCAN_DIV     = 50000,
  parameter int BLINK_FRAMES = 64
) (
  input logic           clk,
  input logic           rst,
  bcd_7seg_scan_if.slave bus
);

  localparam int IDX_W   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int SCAN_W  = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int FRAME_W = $clog2(BLINK_FRAMES + 1);

  localparam logic [IDX_W-1:0]   IDX_LAST   = IDX_W'(NUM_DIGITS - 1);
  localparam logic [SCAN_W-1:0]  SCAN_LAST  = SCAN_W'(SCAN_DIV - 1);
  localparam logic [FRAME_W-1:0] FRAME_LAST = FRAME_W'(BLINK_FRAMES - 1);

  function automatic logic [6:0] seg_decode(input logic [3:0] code);
    logic [6:0] seg;
    case (code)
      4'd0:    seg = 7'b1000000;
      4'd1:    seg = 7'b1111001;
      4'd2:    seg = 7'b0100100;
      4'd3:    seg = 7'b0110000;
      4'd4:    seg = 7'b0011001;
      4'd5:    seg = 7'b0010010;
      4'd6:    seg = 7'b0000010;
      4'd7:    seg = 7'b1111000;
      4'd8:    seg = 7'b0000000;
      4'd9:    seg = 7'b0010000;
      default: seg = 7'b0111111;
    endcase
    return seg;
  endfunction

  function automatic logic bcd_invalid(input logic [4*NUM_DIGITS-1:0] word);
    logic bad;
    bad = 1'b0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      bad = bad | (word[4*i +: 4] > 4'd9);
    end
    return bad;
  endfunction

  logic [4*NUM_DIGITS-1:0] sh_bcd_r;
  logic [NUM_DIGITS-1:0]   sh_dp_r;
  logic                    err_r;
  logic [SCAN_W-1:0]       scan_cnt_r;
  logic [IDX_W-1:0]        idx_r;
  logic [FRAME_W-1:0]      frame_cnt_r;
  logic                    blink_phase_r;
  logic [6:0]              seg_r;
  logic                    dp_r;
  logic [NUM_DIGITS-1:0]   digit_en_r;

  logic [3:0]              cur_code_s;
  logic                    upper_nz_s;
  logic                    blank_s;
  logic [6:0]              seg_nxt_s;
  logic                    dp_nxt_s;
  logic [NUM_DIGITS-1:0]   digit_en_nxt_s;

  // Shadow capture; err tracks the shadow contents so it rises with the capture edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sh_bcd_r <= {(4*NUM_DIGITS){1'b0}};
      sh_dp_r  <= {NUM_DIGITS{1'b0}};
      err_r    <= 1'b0;
    end else begin
      if (bus.load) begin
        sh_bcd_r <= bus.bcd_in;
        sh_dp_r  <= bus.dp_in;
      end else begin
        sh_bcd_r <= sh_bcd_r;
        sh_dp_r  <= sh_dp_r;
      end
      err_r <= bcd_invalid(bus.load ? bus.bcd_in : sh_bcd_r);
    end
  end

  // Scan divider, digit index and blink frame counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scan_cnt_r    <= {SCAN_W{1'b0}};
      idx_r         <= {IDX_W{1'b0}};
      frame_cnt_r   <= {FRAME_W{1'b0}};
      blink_phase_r <= 1'b0;
    end else if (scan_cnt_r == SCAN_LAST) begin
      scan_cnt_r <= {SCAN_W{1'b0}};
      if (idx_r == IDX_LAST) begin
        idx_r <= {IDX_W{1'b0}};
        if (frame_cnt_r == FRAME_LAST) begin
          frame_cnt_r   <= {FRAME_W{1'b0}};
          blink_phase_r <= ~blink_phase_r;
        end else begin
          frame_cnt_r <= frame_cnt_r + FRAME_W'(1);
        end
      end else begin
        idx_r <= idx_r + IDX_W'(1);
      end
    end else begin
      scan_cnt_r <= scan_cnt_r + SCAN_W'(1);
    end
  end

  // Next display values for the currently selected digit.
  always_comb begin
    cur_code_s = sh_bcd_r[{idx_r, 2'b00} +: 4];
    upper_nz_s = 1'b0;
    for (int j = 0; j < NUM_DIGITS; j++) begin
      upper_nz_s = upper_nz_s | ((j >= int'(idx_r)) && (sh_bcd_r[4*j +: 4] != 4'd0));
    end
    blank_s = (bus.blank_lz && (idx_r != {IDX_W{1'b0}}) && !upper_nz_s)
            || (blink_phase_r && bus.blink_mask[idx_r]);
    if (blank_s) begin
      seg_nxt_s = 7'b1111111;
      dp_nxt_s  = 1'b1;
    end else begin
      seg_nxt_s = seg_decode(cur_code_s);
      dp_nxt_s  = ~sh_dp_r[idx_r];
    end
    digit_en_nxt_s = ~(NUM_DIGITS'(1'b1) << idx_r);
  end

  // Glitch-free pin drivers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      seg_r      <= 7'b1111111;
      dp_r       <= 1'b1;
      digit_en_r <= {NUM_DIGITS{1'b1}};
    end else begin
      seg_r      <= seg_nxt_s;
      dp_r       <= dp_nxt_s;
      digit_en_r <= digit_en_nxt_s;
    end
  end

  assign bus.seg_out  = seg_r;
  assign bus.dp_out   = dp_r;
  assign bus.digit_en = digit_en_r;
  assign bus.err      = err_r;

endmodule

// File: tb/tb_bcd_7seg_scan.sv
// Self-checking bench for bcd_7seg_scan: directed scenarios plus random loads,
// checked against a time-based behavioural model of the scanned display.
module tb_bcd_7seg_scan;

  localparam int ND = 4;
  localparam int SD = 4;
  localparam int BF = 2;

  logic clk;
  logic rst;
  int   vectors;
  int   miscompares;

  logic [15:0] m_bcd;
  logic [3:0]  m_dp;
  int          cyc;

  logic [6:0] seg_tbl [0:9] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                                7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};

  bcd_7seg_scan_if #(.NUM_DIGITS(ND)) bus ();

  bcd_7seg_scan #(.NUM_DIGITS(ND), .SCAN_DIV(SD), .BLINK_FRAMES(BF)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic any_invalid(input logic [15:0] w);
    logic bad;
    bad = 1'b0;
    for (int i = 0; i < ND; i++) begin
      if (((w >> (4*i)) % 16) > 9) bad = 1'b1;
    end
    return bad;
  endfunction

  // One clock: predict from elapsed time and model shadow, advance, then compare.
  task automatic step();
    int          d;
    int          phase;
    logic [15:0] tmp;
    logic [3:0]  code;
    logic        blank;
    logic [6:0]  e_seg;
    logic        e_dp;
    logic [3:0]  e_en;
    d     = (cyc / SD) % ND;
    phase = (cyc / (BF*ND*SD)) % 2;
    tmp   = m_bcd >> (4*d);
    code  = tmp[3:0];
    blank = (bus.blank_lz && d >= 1 && tmp == 16'd0) || (phase == 1 && bus.blink_mask[d]);
    e_seg = blank ? 7'b1111111 : (code > 4'd9 ? 7'b0111111 : seg_tbl[code]);
    e_dp  = blank ? 1'b1 : ~m_dp[d];
    e_en  = ~(4'b0001 << d);
    @(posedge clk);
    if (bus.load) begin
      m_bcd = bus.bcd_in;
      m_dp  = bus.dp_in;
    end
    cyc++;
    #1;
    chk("seg_out", 16'(bus.seg_out), 16'(e_seg));
    chk("dp_out", 16'(bus.dp_out), 16'(e_dp));
    chk("digit_en", 16'(bus.digit_en), 16'(e_en));
    chk("err", 16'(bus.err), 16'(any_invalid(m_bcd)));
  endtask

  task automatic load_run(input logic [15:0] v, input logic [3:0] dp, input int n);
    bus.bcd_in = v;
    bus.dp_in  = dp;
    bus.load   = 1'b1;
    step();
    bus.load   = 1'b0;
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_seg"}, 16'(bus.seg_out), 16'h007F);
    chk({tag, "_dp"}, 16'(bus.dp_out), 16'h0001);
    chk({tag, "_en"}, 16'(bus.digit_en), 16'h000F);
    chk({tag, "_err"}, 16'(bus.err), 16'h0000);
  endtask

  initial begin
    vectors       = 0;
    miscompares   = 0;
    rst           = 1'b1;
    bus.bcd_in    = 16'h0000;
    bus.dp_in     = 4'b0000;
    bus.load      = 1'b0;
    bus.blank_lz  = 1'b0;
    bus.blink_mask = 4'b0000;
    m_bcd = 16'h0000;
    m_dp  = 4'b0000;
    cyc   = 0;
    #2;
    chk_reset_outputs("reset");
    @(posedge clk);
    #1;
    rst = 1'b0;

    step();
    load_run(16'h1234, 4'b0000, 20);
    bus.blank_lz = 1'b1;
    load_run(16'h0070, 4'b0000, 16);
    load_run(16'h0000, 4'b0000, 16);
    bus.blank_lz = 1'b0;
    load_run(16'h00A5, 4'b0000, 16);
    load_run(16'h0005, 4'b0000, 4);
    bus.blink_mask = 4'b0001;
    load_run(16'h8888, 4'b0000, 70);
    bus.blink_mask = 4'b0000;
    load_run(16'h1234, 4'b0100, 16);

    // Random loads, including back-to-back captures and invalid codes.
    for (int i = 0; i < 300; i++) begin
      bus.bcd_in     = 16'($urandom) >> (4 * $urandom_range(0, 4));
      bus.dp_in      = 4'($urandom);
      bus.load       = ($urandom_range(0, 3) == 0);
      bus.blank_lz   = 1'($urandom);
      bus.blink_mask = 4'($urandom);
      step();
    end
    bus.load = 1'b0;

    // Asynchronous reset in the middle of digit 2 with an error pending.
    load_run(16'h9A15, 4'b1111, 0);
    while (!(((cyc / SD) % ND) == 2 && (cyc % SD) == 1)) step();
    #2;
    rst = 1'b1;
    #1;
    chk_reset_outputs("async_rst");
    m_bcd = 16'h0000;
    m_dp  = 4'b0000;
    cyc   = 0;
    bus.blank_lz   = 1'b0;
    bus.blink_mask = 4'b0000;
    @(posedge clk);
    #1;
    chk_reset_outputs("rst_held");
    rst = 1'b0;
    for (int i = 0; i < 8; i++) step();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
